// File: rtl/fetch_pkg.sv
// Shared defaults for the instruction-fetch front end and the counter-width helper.
package fetch_pkg;
  localparam int FETCH_DEPTH    = 4;
  localparam int FETCH_RESET_PC = 0;
  localparam int FETCH_PC_STEP  = 4;

  // Counters must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: pointer-based ring with synchronous clear and a zeroed head when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [cnt_w(DEPTH)-1:0]  occ_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] occ_q;
  logic          do_pop;

  assign do_pop = pop_i && (occ_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      occ_q <= '0;
    end else if (clr_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      occ_q <= occ_q + CW'(push_i) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wr_q] <= din_i;
  end

  assign head_o = (occ_q != '0) ? mem_q[rd_q] : '0;
  assign occ_o  = occ_q;
endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: PC generator, credit-limited in-order IM requests, prefetch FIFO,
// and flush handling that discards responses still in flight for the old path.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = FETCH_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC),
  parameter int                PC_STEP  = FETCH_PC_STEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_addr,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic              im_ready,
  input  logic              im_rvalid,
  input  logic [INST_W-1:0] im_rdata,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  input  logic              id_ready
);
  localparam int CW = cnt_w(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]     outst_q, outst_d, drop_q, drop_d, occ;
  logic [CW:0]       inflight;
  logic              accept, stale, push, pop;
  entry_t            push_ent, head;

  // Credits cover both buffered entries and responses not yet returned.
  assign inflight = {1'b0, occ} + {1'b0, outst_q};
  assign im_req   = rst && !flush && (inflight < (CW+1)'(DEPTH));
  assign im_addr  = pc_q;
  assign accept   = im_req && im_ready;
  assign stale    = (drop_q != '0);
  assign push     = im_rvalid && !flush && !stale;
  assign pop      = id_valid && id_ready && !flush;
  assign push_ent = '{pc: resp_pc_q, inst: im_rdata};

  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    outst_d   = outst_q;
    drop_d    = drop_q;
    if (flush) begin
      pc_d      = new_addr;
      resp_pc_d = new_addr;
      outst_d   = outst_q - CW'(im_rvalid);
      drop_d    = outst_q - CW'(im_rvalid);
    end else begin
      if (accept)            pc_d      = pc_q + ADDR_W'(PC_STEP);
      if (push)              resp_pc_d = resp_pc_q + ADDR_W'(PC_STEP);
      if (im_rvalid && stale) drop_d   = drop_q - 1'b1;
      outst_d = outst_q + CW'(accept) - CW'(im_rvalid);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      drop_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
    end
  end

  fetch_fifo #(.W(ADDR_W + INST_W), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst),
    .clr_i  (flush),
    .push_i (push),
    .din_i  (push_ent),
    .pop_i  (pop),
    .head_o (head),
    .occ_o  (occ)
  );

  assign id_valid = (occ != '0);
  assign id_pc    = head.pc;
  assign id_inst  = head.inst;

  // IM must never answer a request that was not issued.
  rsp_without_req: assert property (@(posedge clk) disable iff (!rst)
    im_rvalid |-> (outst_q != '0));
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model plus an in-order IM model.
module tb_fetch_queue;
  localparam int AW = 32, IW = 32, DEPTH = 4;

  logic          clk = 1'b0, rst = 1'b0, flush = 1'b0, im_ready = 1'b0;
  logic          im_rvalid = 1'b0, id_ready = 1'b0;
  logic [AW-1:0] new_addr = '0, im_addr, id_pc;
  logic [IW-1:0] im_rdata = '0, id_inst;
  logic          im_req, id_valid;

  always #5 clk = ~clk;

  fetch_queue #(.ADDR_W(AW), .INST_W(IW), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .new_addr(new_addr),
    .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready),
    .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .id_ready(id_ready)
  );

  int n_cmp = 0, n_err = 0;

  // Reference state
  logic [31:0] m_pc, m_rpc;
  int          m_outst, m_drop;
  logic [31:0] mq_pc[$], mq_inst[$];
  // IM model: accepted addresses with the cycle their response becomes due
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc, lat, n_acc;
  logic [31:0] got[$];
  logic        obs_req, obs_valid;
  logic [31:0] obs_addr;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    m_pc = 0; m_rpc = 0; m_outst = 0; m_drop = 0;
    mq_pc.delete(); mq_inst.delete();
    pend_addr.delete(); pend_due.delete();
    got.delete();
    cyc = 0;
  endfunction

  task automatic step(input logic fl, input logic [31:0] na, input logic ir, input logic idr);
    logic rv, e_req;
    logic [31:0] rd;
    rv = (pend_addr.size() > 0) && (pend_due[0] <= cyc);
    rd = rv ? inst_of(pend_addr[0]) : $urandom;
    flush = fl; new_addr = na; im_ready = ir; id_ready = idr;
    im_rvalid = rv; im_rdata = rd;
    #2;
    e_req = !fl && (mq_pc.size() + m_outst < DEPTH);
    chk("im_req",   32'(im_req), 32'(e_req));
    chk("im_addr",  im_addr, m_pc);
    chk("id_valid", 32'(id_valid), 32'(mq_pc.size() > 0));
    chk("id_pc",    id_pc,   (mq_pc.size() > 0) ? mq_pc[0] : 32'h0);
    chk("id_inst",  id_inst, (mq_pc.size() > 0) ? mq_inst[0] : 32'h0);
    if (id_valid) chk("inst_matches_pc", id_inst, inst_of(id_pc));
    obs_req = im_req; obs_addr = im_addr; obs_valid = id_valid;
    if (id_valid && idr && !fl) got.push_back(id_pc);
    // IM environment reacts to the handshake as the DUT presents it
    if (rv) begin void'(pend_addr.pop_front()); void'(pend_due.pop_front()); end
    if (im_req && ir) begin
      n_acc++;
      pend_addr.push_back(im_addr);
      pend_due.push_back(cyc + lat);
    end
    // Reference update
    if (fl) begin
      mq_pc.delete(); mq_inst.delete();
      m_pc = na; m_rpc = na;
      m_outst = m_outst - int'(rv);
      m_drop = m_outst;
    end else begin
      if (mq_pc.size() > 0 && idr) begin
        void'(mq_pc.pop_front()); void'(mq_inst.pop_front());
      end
      if (rv) begin
        m_outst--;
        if (m_drop > 0) m_drop--;
        else begin mq_pc.push_back(m_rpc); mq_inst.push_back(rd); m_rpc = m_rpc + 4; end
      end
      if (e_req && ir) begin m_pc = m_pc + 4; m_outst++; end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic reset_seq();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      flush = 1'($urandom); im_ready = 1'($urandom); im_rvalid = 1'($urandom);
      id_ready = 1'($urandom); new_addr = $urandom; im_rdata = $urandom;
      #3;
      chk("rst_im_req",   32'(im_req), 32'h0);
      chk("rst_id_valid", 32'(id_valid), 32'h0);
      chk("rst_id_pc",    id_pc, 32'h0);
      chk("rst_id_inst",  id_inst, 32'h0);
      @(posedge clk); #1;
    end
    flush = 1'b0; im_rvalid = 1'b0; im_ready = 1'b0; id_ready = 1'b0;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic wait_first(input string n, input logic [31:0] exp);
    for (int i = 0; i < 20 && got.size() == 0; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk({n, "_delivered"}, 32'(got.size() > 0), 32'h1);
    if (got.size() > 0) chk(n, got[0], exp);
  endtask

  initial begin
    lat = 1; n_acc = 0; cyc = 0;
    m_pc = 0; m_rpc = 0; m_outst = 0; m_drop = 0;
    obs_req = 0; obs_valid = 0; obs_addr = 0;

    // Reset, then a full-rate stream
    reset_seq();
    lat = 1;
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("first_req",  32'(obs_req), 32'h1);
    chk("first_addr", obs_addr, 32'h0);
    repeat (7) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("stream_count", got.size(), 6);
    for (int i = 0; i < 4; i++)
      if (got.size() > i) chk("stream_pc", got[i], 32'(i * 4));

    // Decoder backpressure fills exactly DEPTH credits
    reset_seq();
    lat = 1; n_acc = 0;
    repeat (8) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_requests", n_acc, DEPTH);
    chk("bp_req_off",  32'(obs_req), 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_req_again", 32'(obs_req), 32'h1);
    chk("bp_addr",      obs_addr, 32'h10);

    // Flush with two requests still outstanding
    reset_seq();
    lat = 3;
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h100, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("flush_req",  32'(obs_req), 32'h1);
    chk("flush_addr", obs_addr, 32'h100);
    wait_first("flush_first_pc", 32'h100);

    // Flush, response and pop all in one cycle with two entries buffered
    reset_seq();
    lat = 1;
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h200, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("simul_empty", 32'(obs_valid), 32'h0);
    chk("simul_addr",  obs_addr, 32'h200);
    wait_first("simul_first_pc", 32'h200);

    // Asynchronous reset in the middle of a cycle
    reset_seq();
    lat = 1;
    repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0);
    im_rvalid = 1'b0; flush = 1'b0;
    #2; rst = 1'b0; #1;
    chk("async_im_req",   32'(im_req), 32'h0);
    chk("async_id_valid", 32'(id_valid), 32'h0);
    chk("async_id_pc",    id_pc, 32'h0);
    chk("async_id_inst",  id_inst, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("after_async_req",  32'(obs_req), 32'h1);
    chk("after_async_addr", obs_addr, 32'h0);
    wait_first("after_async_pc", 32'h0);

    // Randomized traffic: flushes, backpressure, variable IM latency, PC wrap
    reset_seq();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] na;
      lat = int'($urandom_range(1, 4));
      na  = ($urandom % 4 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      step(1'($urandom % 16 == 0), na, 1'($urandom % 4 != 0), 1'($urandom % 3 != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch front end that replaces the single-entry fetch path (program counter plus fetch/decode register) with a PC generator, a credit-limited in-order request stream to instruction memory, and a DEPTH-entry prefetch FIFO. It sits between IM and the decoder. It decouples variable IM latency from decoder stalls and supports branch redirect and flush from execute, discarding in-flight stale responses.

Parameters:
ADDR_W, 32, width of PC and IM address
INST_W, 32, instruction width
DEPTH, 4, prefetch FIFO entries; power of two, >= 2
RESET_PC, 0, PC value loaded at reset
PC_STEP, 4, PC increment per accepted request

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
flush  in  1  branch taken in execute; redirect fetch
new_addr  in  ADDR_W  redirect target, valid when flush=1
im_req  out  1  fetch request valid
im_addr  out  ADDR_W  fetch address (current PC register)
im_ready  in  1  IM accepts request this cycle
im_rvalid  in  1  IM response valid; responses are in order
im_rdata  in  INST_W  IM response instruction
id_valid  out  1  head entry valid to decoder
id_pc  out  ADDR_W  PC of head entry, 0 when empty
id_inst  out  INST_W  instruction of head entry, 0 when empty
id_ready  in  1  decoder consumes head this cycle

Behaviour:
- Interface: one clock, clk; asynchronous active-low reset, rst.
- Reset (rst=0, async): pc=RESET_PC, resp_pc=RESET_PC, FIFO empty, outst=0, drop=0. Outputs: im_req=0, id_valid=0, id_pc=0, id_inst=0.
- Counters occ, outst, drop are $clog2(DEPTH)+1 bits. Invariant: occ+outst <= DEPTH.
- Issue: im_req = !flush && (occ+outst < DEPTH).
  - Accept = im_req && im_ready.
  - On accept: pc += PC_STEP (wraps mod 2^ADDR_W); outst++.
  - im_addr must hold stable while im_req=1 && !im_ready.
- Response, when im_rvalid=1:
  - drop>0: discard; drop--; outst--.
  - drop==0: push {resp_pc, im_rdata}; resp_pc += PC_STEP; outst--.
- Pop: id_valid && id_ready removes the head.
- Response-to-id_valid latency is 1 cycle; there is no bypass.
- Push and pop in the same cycle at full or empty are both legal; occ is unchanged.
- Flush takes priority in its cycle:
  - FIFO cleared; any pop that cycle is ignored.
  - pc and resp_pc are set to new_addr; no request is issued.
  - drop = outst - (im_rvalid ? 1 : 0), counting stale responses still to come; outst takes the same value.
  - A response arriving in the flush cycle is discarded.
  - Next cycle: im_req may assert with im_addr=new_addr.
- Back-to-back flushes: the second flush overrides; drop is recomputed from the current outst.
- Flush while drop>0 is legal; stale responses are never delivered.
- A response with outst==0 is a protocol error; assertion only, with no RTL recovery.
- id_pc/id_inst are driven from the FIFO head register and are 0 when occ==0.
- Steady state with im_ready=1, single-cycle IM and id_ready=1 sustains 1 instruction/cycle.

Decomposition:
- Shared package fetch_pkg: default constants (FETCH_DEPTH, FETCH_RESET_PC, FETCH_PC_STEP) and a count-width function.
- Entry struct {pc, inst} is declared locally as it depends on parameters.
- One sub-module, fetch_fifo: synchronous FIFO parametrised by width and depth. It provides push/pop/clear, occ output and async active-low reset.
- Top level holds the PC, resp_pc, outst/drop counters and issue logic.

Test Plan:
1. Reset: hold rst=0 with random inputs -> im_req=0, id_valid=0, id_pc=0. Release rst -> first cycle im_req=1, im_addr=0x0.
2. Stream: im_ready=1, rvalid 1 cycle after accept, id_ready=1 -> id_pc 0x0,0x4,0x8,0xC on consecutive cycles; id_inst matches IM model.
3. Backpressure (DEPTH=4): id_ready=0 -> exactly 4 requests (0x0..0xC), then im_req=0. Set id_ready=1 for one cycle -> one pop, then one request at 0x10.
4. Flush with 2 outstanding: flush=1, new_addr=0x100 -> next im_addr=0x100; the 2 stale responses are dropped; first id_pc=0x100.
5. Simultaneous: flush, im_rvalid and pop in the same cycle with occ=2 -> occ=0, no push, drop=outst-1, next delivered id_pc=new_addr.
6. Async reset mid-stream: assert rst between clock edges with occ=3, outst=1 -> outputs zero immediately. After release, im_addr=RESET_PC and no stale response is delivered; the IM model also resets.
